// File: rtl/kij_sequencer.sv
// kij_sequencer: multi-pass kernel-index controller (fill, load, flush, execute, drain, read-out)
module kij_sequencer #(
   parameter int row     = 8,
   parameter int col     = 8,
   parameter int num_inp = 64,
   parameter int kij_len = 9,
   parameter int aw      = $clog2(num_inp)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     full_l0,
   input  logic                     ready_l0,
   input  logic                     o_valid,
   input  logic                     psum_rd_req,
   output logic                     wr_l0,
   output logic                     rd_l0,
   output logic                     mode,
   output logic [1:0]               inst_w,
   output logic                     rd_ofifo,
   output logic                     psum_wen,
   output logic                     psum_ren,
   output logic [aw-1:0]            psum_addr,
   output logic                     acc,
   output logic                     relu,
   output logic [$clog2(kij_len):0] kij_idx,
   output logic                     iter_done,
   output logic                     compute_done,
   output logic                     busy
);
   localparam int kw = $clog2(kij_len) + 1;
   localparam int cw = $clog2(num_inp + row + col) + 1;
   typedef enum logic [3:0] {IDLE, W_FILL, W_LOAD, W_FLUSH, A_FILL, EXEC, DRAIN, ITER, DONE, READ} state_t;
   state_t state, nxt, go;
   logic [cw-1:0] cnt, lim;
   logic step, jump, last, pop;
   logic [aw-1:0] waddr;
   assign busy = state != IDLE;
   assign pop = rd_ofifo & ~abort;
   // state register
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= nxt;
   // per-state strobes; step marks a cycle that advances the phase count toward lim
   always_comb begin
      wr_l0 = 1'b0;
      rd_l0 = 1'b0;
      mode = 1'b0;
      inst_w = 2'b00;
      rd_ofifo = 1'b0;
      psum_ren = 1'b0;
      iter_done = 1'b0;
      compute_done = 1'b0;
      step = 1'b0;
      jump = 1'b0;
      lim = '0;
      go = state;
      case (state)
         IDLE:    begin jump = start; go = W_FILL; end
         W_FILL:  begin wr_l0 = ~full_l0; step = ~full_l0; lim = cw'(row); go = W_LOAD; end
         W_LOAD:  begin rd_l0 = ready_l0; inst_w = 2'b01; step = ready_l0; lim = cw'(row); go = W_FLUSH; end
         W_FLUSH: begin step = 1'b1; lim = cw'(row + col); go = A_FILL; end
         A_FILL:  begin wr_l0 = ~full_l0; mode = 1'b1; step = ~full_l0; lim = cw'(num_inp); go = EXEC; end
         EXEC:    begin rd_l0 = ready_l0; inst_w = 2'b10; step = ready_l0; lim = cw'(num_inp); go = DRAIN; end
         DRAIN:   begin rd_ofifo = o_valid; step = o_valid; lim = cw'(num_inp); go = ITER; end
         ITER:    begin iter_done = 1'b1; jump = 1'b1; go = (kij_idx + kw'(1) < kw'(kij_len)) ? W_FILL : DONE; end
         DONE:    begin compute_done = 1'b1; jump = psum_rd_req | ~start; go = psum_rd_req ? READ : IDLE; end
         READ:    begin compute_done = 1'b1; psum_ren = 1'b1; step = 1'b1; lim = cw'(num_inp); go = DONE; end
         default: begin jump = 1'b1; go = IDLE; end
      endcase
      last = step && cnt == lim - cw'(1);
      nxt = abort ? IDLE : (last || jump) ? go : state;
      psum_addr = psum_ren ? cnt[aw-1:0] : waddr;
   end
   // phase counter clears on every state change; kernel index steps in ITER
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         cnt <= '0;
         kij_idx <= '0;
      end else begin
         cnt <= (nxt != state) ? '0 : cnt + cw'(step);
         kij_idx <= (nxt == IDLE) ? '0 : (state == ITER) ? kij_idx + kw'(1) : kij_idx;
      end
   // psum write lags its OFIFO pop by one cycle; flags are captured with the pop
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         psum_wen <= 1'b0;
         acc <= 1'b0;
         relu <= 1'b0;
         waddr <= '0;
      end else begin
         psum_wen <= pop;
         acc <= pop && kij_idx != '0;
         relu <= pop && kij_idx == kw'(kij_len - 1);
         waddr <= pop ? cnt[aw-1:0] : '0;
      end
endmodule

// File: tb/tb_kij_sequencer.sv
// tb_kij_sequencer: phase-table reference model with directed and random stalls
module tb_kij_sequencer;
   localparam int ROW = 8, COL = 8, NI = 64, KL = 9, AW = 6, KW = 5;
   logic clk = 1'b0;
   logic reset, start, abort, full_l0, ready_l0, o_valid, psum_rd_req;
   logic wr_l0, rd_l0, mode, rd_ofifo, psum_wen, psum_ren, acc, relu, iter_done, compute_done, busy;
   logic [1:0] inst_w;
   logic [AW-1:0] psum_addr;
   logic [KW-1:0] kij_idx;
   int checks = 0, errors = 0;
   int p = 0, cnt = 0, k = 0;
   logic m_wen = 1'b0, m_acc = 1'b0, m_relu = 1'b0;
   logic [AW-1:0] m_addr = '0;
   int need [10] = '{0, ROW, ROW, ROW + COL, NI, NI, NI, 1, 0, NI};
   int since_iter, gaps[$], busy_cycles, wr_tot, rd_tot, rdo_tot, wen_tot, acc_tot, relu_tot, addr_sum, ren_tot, ren_sum, cd_tot;

   always #5 clk = ~clk;

   kij_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .full_l0(full_l0), .ready_l0(ready_l0),
      .o_valid(o_valid), .psum_rd_req(psum_rd_req), .wr_l0(wr_l0), .rd_l0(rd_l0), .mode(mode),
      .inst_w(inst_w), .rd_ofifo(rd_ofifo), .psum_wen(psum_wen), .psum_ren(psum_ren),
      .psum_addr(psum_addr), .acc(acc), .relu(relu), .kij_idx(kij_idx), .iter_done(iter_done),
      .compute_done(compute_done), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] outvec();
      outvec = {8'd0, wr_l0, rd_l0, mode, inst_w, rd_ofifo, psum_wen, psum_ren, psum_addr,
                acc, relu, kij_idx, iter_done, compute_done, busy};
   endfunction

   // phases: 0 idle, 1 w_fill, 2 w_load, 3 w_flush, 4 a_fill, 5 exec, 6 drain, 7 iter, 8 done, 9 read
   task automatic tick();
      logic [31:0] want;
      logic q;
      @(negedge clk);
      want = {8'd0, (p == 1 || p == 4) && !full_l0, (p == 2 || p == 5) && ready_l0, p == 4,
              2'(p == 2 ? 1 : p == 5 ? 2 : 0), p == 6 && o_valid, m_wen, p == 9,
              (p == 9) ? AW'(cnt) : m_addr, m_acc, m_relu, KW'(k), p == 7, p >= 8, p != 0};
      chk("outputs", outvec(), want);
      since_iter++;
      if (iter_done) begin
         gaps.push_back(since_iter);
         since_iter = 0;
      end
      if (busy && !compute_done) busy_cycles++;
      wr_tot += int'(wr_l0);
      rd_tot += int'(rd_l0);
      rdo_tot += int'(rd_ofifo);
      wen_tot += int'(psum_wen);
      acc_tot += int'(psum_wen && acc);
      relu_tot += int'(psum_wen && relu);
      addr_sum += psum_wen ? int'(psum_addr) : 0;
      ren_tot += int'(psum_ren);
      ren_sum += psum_ren ? int'(psum_addr) : 0;
      cd_tot += int'(compute_done);
      q = (p == 1 || p == 4) ? !full_l0 : (p == 2 || p == 5) ? ready_l0 : (p == 6) ? o_valid : (p == 3 || p == 9);
      m_wen = p == 6 && o_valid && !abort;
      m_acc = m_wen && k != 0;
      m_relu = m_wen && k == KL - 1;
      m_addr = m_wen ? AW'(cnt) : '0;
      if (abort) begin
         p = 0; cnt = 0; k = 0;
      end else if (p == 0) p = start ? 1 : 0;
      else if (p == 7) begin
         k++;
         p = (k < KL) ? 1 : 8;
      end else if (p == 8) begin
         if (psum_rd_req) p = 9;
         else if (!start) begin p = 0; k = 0; end
      end else if (q) begin
         cnt++;
         if (cnt == need[p]) begin
            p = (p == 9) ? 8 : p + 1;
            cnt = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // sty: 0 no stalls, 1 directed stalls then random, 2 random stalls
   task automatic run_job(input int sty);
      gaps.delete();
      {wr_tot, rd_tot, rdo_tot, wen_tot, acc_tot, relu_tot, addr_sum} = '0;
      start = 1'b1; abort = 1'b0; psum_rd_req = 1'b0; full_l0 = 1'b0; ready_l0 = 1'b1; o_valid = 1'b1;
      tick();
      since_iter = 0;
      busy_cycles = 0;
      for (int n = 0; n < 6000 && !compute_done; n++) begin
         full_l0 = 1'b0; ready_l0 = 1'b1; o_valid = 1'b1;
         if (sty == 1 && gaps.size() == 0) full_l0 = since_iter >= 50 && since_iter <= 54;
         else if (sty == 1 && gaps.size() == 1) o_valid = (since_iter % 2 == 0);
         else if (sty != 0) begin
            full_l0 = $urandom_range(0, 3) == 0;
            ready_l0 = $urandom_range(0, 3) != 0;
            o_valid = $urandom_range(0, 3) != 0;
         end
         tick();
      end
      chk("job_done", compute_done, 1);
      chk("passes", gaps.size(), KL);
      chk("wen_total", wen_tot, NI * KL);
      chk("acc_total", acc_tot, NI * (KL - 1));
      chk("relu_total", relu_tot, NI);
      chk("addr_sum", addr_sum, KL * NI * (NI - 1) / 2);
   endtask

   task automatic read_out();
      psum_rd_req = 1'b1;
      tick();
      psum_rd_req = 1'b0;
      ren_tot = 0; ren_sum = 0; cd_tot = 0;
      repeat (NI) tick();
      chk("ren_total", ren_tot, NI);
      chk("ren_addr_sum", ren_sum, NI * (NI - 1) / 2);
      chk("done_in_read", cd_tot, NI);
      chk("back_to_done", {compute_done, psum_ren}, 2'b10);
      start = 1'b0;
      tick();
      chk("idle_after_done", {busy, compute_done, kij_idx}, 0);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; abort = 1'b0; full_l0 = 1'b0; ready_l0 = 1'b1; o_valid = 1'b0; psum_rd_req = 1'b0;
      #12;
      chk("reset_state", outvec(), 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      run_job(0);
      foreach (gaps[i]) chk("pass_len", gaps[i], 225);
      chk("done_latency", busy_cycles, 2025);
      chk("words_written", wr_tot, KL * (ROW + NI));
      chk("words_read", rd_tot, KL * (ROW + NI));
      read_out();
      run_job(1);
      chk("full_stall_pass", gaps[0], 230);
      chk("drain_stall_pass", gaps[1] >= 288 && gaps[1] <= 289, 1);
      chk("words_written_stall", wr_tot, KL * (ROW + NI));
      chk("pops_stall", rdo_tot, KL * NI);
      read_out();
      start = 1'b1; full_l0 = 1'b0; ready_l0 = 1'b1; o_valid = 1'b1;
      tick();
      for (int n = 0; n < 2000 && !(kij_idx == 3 && inst_w == 2'b10); n++) tick();
      chk("reach_pass3_exec", kij_idx == 3 && inst_w == 2'b10, 1);
      repeat (5) tick();
      abort = 1'b1; start = 1'b0;
      tick();
      abort = 1'b0;
      chk("abort_outputs", outvec(), 0);
      tick();
      run_job(2);
      start = 1'b0;
      tick();
      start = 1'b1; full_l0 = 1'b0; ready_l0 = 1'b1; o_valid = 1'b1;
      tick();
      for (int n = 0; n < 1000 && !rd_ofifo; n++) tick();
      chk("reach_drain", rd_ofifo, 1);
      repeat (10) tick();
      #2;
      reset = 1'b0;
      start = 1'b0;
      #1;
      chk("async_reset", outvec(), 0);
      p = 0; cnt = 0; k = 0; m_wen = 1'b0; m_acc = 1'b0; m_relu = 1'b0; m_addr = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      run_job(2);
      read_out();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
